// File: rtl/decap_packet_top.sv
// Receive-side decapsulation: strips per-word headers from the Aurora stream and
// reassembles NUMBER_PACKET payload chunks into one {data, addr} DFX word.
`timescale 1ns/1ps
module decap_packet_top #(
  parameter int DATA_WIDTH             = 1024,
  parameter int ADDR_WIDTH             = 10,
  parameter int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int NUMBER_PACKET          = 19,
  parameter int TTL_WIDTH              = $clog2(3),
  parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH,
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH,
  parameter int TIMEOUT_CYCLES         = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
  input  logic                         data_recv_valid,
  output logic [DATA_WIDTH-1:0]        data_arbiter_recv,
  output logic [ADDR_WIDTH-1:0]        router_dst_addr_recv,
  output logic [HEADER_WIDTH-1:0]      header_pkt_recv,
  output logic                         decap_done,
  output logic                         decap_err
);

  localparam int IDX_WIDTH = $clog2(NUMBER_PACKET);
  localparam int LAST_IDX  = NUMBER_PACKET - 1;
  localparam int LAST_BITS = DATA_DFX_WIDTH - LAST_IDX * PAYLOAD_WIDTH;
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [HEADER_WIDTH-1:0]           hdr_in;
  logic [PAYLOAD_WIDTH-1:0]          payload_in;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_in;
  logic [IDX_WIDTH-1:0]              idx_in;
  logic [TTL_WIDTH-1:0]              ttl_in;

  logic [HEADER_WIDTH-1:0]           hdr_q;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_q;
  logic [TTL_WIDTH-1:0]              ttl_q;

  logic [IDX_WIDTH-1:0] exp_idx_q, exp_idx_d;
  logic [CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic                 store_en;
  logic                 latch_hdr;
  logic                 err_d;
  logic                 fields_match;

  // Final chunk only keeps its useful low bits; the rest of that word is padding.
  logic [PAYLOAD_WIDTH-1:0] chunk_q [LAST_IDX];
  logic [LAST_BITS-1:0]     last_q;
  logic [DATA_DFX_WIDTH-1:0] dfx_buf;

  assign hdr_in     = data_recv[AURORA_DATA_WIDTH-1 -: HEADER_WIDTH];
  assign payload_in = data_recv[PAYLOAD_WIDTH-1:0];
  assign router_in  = hdr_in[HEADER_WIDTH-1 -: RECOGNIZE_ROUTER_WIDTH];
  assign idx_in     = hdr_in[TTL_WIDTH +: IDX_WIDTH];
  assign ttl_in     = hdr_in[TTL_WIDTH-1:0];

  assign router_q = hdr_q[HEADER_WIDTH-1 -: RECOGNIZE_ROUTER_WIDTH];
  assign ttl_q    = hdr_q[TTL_WIDTH-1:0];

  assign fields_match = (router_in == router_q) && (ttl_in == ttl_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_idx_d  = exp_idx_q;
    idle_cnt_d = idle_cnt_q;
    store_en   = 1'b0;
    latch_hdr  = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // DONE lasts one cycle but accepts a new chunk 0 exactly like IDLE.
        state_d    = IDLE;
        idle_cnt_d = '0;
        if (data_recv_valid) begin
          if (idx_in == '0) begin
            store_en  = 1'b1;
            latch_hdr = 1'b1;
            exp_idx_d = IDX_WIDTH'(1);
            state_d   = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (data_recv_valid) begin
          idle_cnt_d = '0;
          if ((idx_in == exp_idx_q) && fields_match) begin
            store_en = 1'b1;
            if (idx_in == IDX_WIDTH'(LAST_IDX)) begin
              exp_idx_d = '0;
              state_d   = DONE;
            end else begin
              exp_idx_d = exp_idx_q + 1'b1;
            end
          end else if (idx_in == '0) begin
            err_d     = 1'b1;
            store_en  = 1'b1;
            latch_hdr = 1'b1;
            exp_idx_d = IDX_WIDTH'(1);
          end else begin
            err_d     = 1'b1;
            exp_idx_d = '0;
            state_d   = IDLE;
          end
        end else if (idle_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          idle_cnt_d = '0;
          exp_idx_d  = '0;
          state_d    = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    dfx_buf = '0;
    for (int unsigned k = 0; k < LAST_IDX; k++) begin
      dfx_buf[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = chunk_q[k];
    end
    dfx_buf[DATA_DFX_WIDTH-1 -: LAST_BITS] = last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_idx_q            <= '0;
      idle_cnt_q           <= '0;
      hdr_q                <= '0;
      last_q               <= '0;
      for (int unsigned k = 0; k < LAST_IDX; k++) begin
        chunk_q[k] <= '0;
      end
      data_arbiter_recv    <= '0;
      router_dst_addr_recv <= '0;
      header_pkt_recv      <= '0;
      decap_done           <= 1'b0;
      decap_err            <= 1'b0;
    end else begin
      exp_idx_q  <= exp_idx_d;
      idle_cnt_q <= idle_cnt_d;
      decap_err  <= err_d;
      decap_done <= (state_q == DONE);

      if (latch_hdr) begin
        hdr_q <= hdr_in;
      end

      if (store_en) begin
        for (int unsigned k = 0; k < LAST_IDX; k++) begin
          if (idx_in == IDX_WIDTH'(k)) begin
            chunk_q[k] <= payload_in;
          end
        end
        if (idx_in == IDX_WIDTH'(LAST_IDX)) begin
          last_q <= payload_in[LAST_BITS-1:0];
        end
      end

      // Nonblocking reads take the finished frame even if chunk 0 of the next lands now.
      if (state_q == DONE) begin
        data_arbiter_recv    <= dfx_buf[DATA_DFX_WIDTH-1:ADDR_WIDTH];
        router_dst_addr_recv <= dfx_buf[ADDR_WIDTH-1:0];
        header_pkt_recv      <= hdr_q;
      end
    end
  end

endmodule

// File: tb/tb_decap_packet_top.sv
// Scoreboard bench for decap_packet_top: directed frames push expected pulses,
// a negedge monitor pops and compares on every decap_done / decap_err.
`timescale 1ns/1ps
module tb_decap_packet_top;

  localparam int DW  = 1024;
  localparam int AW  = 10;
  localparam int DFX = DW + AW;
  localparam int NP  = 19;
  localparam int PW  = 55;
  localparam int HW  = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   data_recv;
  logic          data_recv_valid;
  logic [DW-1:0] data_arbiter_recv;
  logic [AW-1:0] router_dst_addr_recv;
  logic [HW-1:0] header_pkt_recv;
  logic          decap_done;
  logic          decap_err;

  always #5 clk = ~clk;

  decap_packet_top #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .NUMBER_PACKET  (NP),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .data_recv            (data_recv),
    .data_recv_valid      (data_recv_valid),
    .data_arbiter_recv    (data_arbiter_recv),
    .router_dst_addr_recv (router_dst_addr_recv),
    .header_pkt_recv      (header_pkt_recv),
    .decap_done           (decap_done),
    .decap_err            (decap_err)
  );

  typedef struct {
    bit            is_done;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [HW-1:0] hdr;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int lane;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      lane = 0;
      for (int i = DW/32 - 1; i >= 0; i--) begin
        if (act[i*32 +: 32] !== exp[i*32 +: 32]) lane = i;
      end
      $display("FAIL %s: lane %0d got %h expected %h", name, lane, act[lane*32 +: 32], exp[lane*32 +: 32]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (decap_done === 1'b1 || decap_err === 1'b1)) begin
      if (decap_done === 1'b1) done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got done=%b err=%b expected no pulse", decap_done, decap_err);
      end else begin
        e = sb.pop_front();
        check_val("pulse_kind", 64'({decap_done, decap_err}), e.is_done ? 64'd2 : 64'd1);
        if (e.is_done) begin
          check_data("done_data", data_arbiter_recv, e.data);
          check_val("done_addr", 64'(router_dst_addr_recv), 64'(e.addr));
          check_val("done_header", 64'(header_pkt_recv), 64'(e.hdr));
        end
      end
    end
  end

  function automatic logic [DFX-1:0] make_dfx(input logic [31:0] base, input logic [31:0] step,
                                              input logic [AW-1:0] addr);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = base + step * 32'(i % 8);
    return {d, addr};
  endfunction

  function automatic logic [63:0] mk_word(input logic [DFX-1:0] dfx, input logic [1:0] router,
                                          input int idx, input logic [1:0] ttl);
    logic [NP*PW-1:0] ext;
    logic [4:0]       idx5;
    ext = '0;
    ext[DFX-1:0] = dfx;
    idx5 = 5'(idx);
    return {router, idx5, ttl, ext[(idx % NP)*PW +: PW]};
  endfunction

  task automatic send_word(input logic [63:0] w);
    data_recv       = w;
    data_recv_valid = 1'b1;
    @(posedge clk);
    #1;
    data_recv_valid = 1'b0;
    data_recv       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_err();
    exp_t e;
    e.is_done = 1'b0;
    e.data    = '0;
    e.addr    = '0;
    e.hdr     = '0;
    sb.push_back(e);
  endtask

  task automatic push_done(input logic [DFX-1:0] dfx, input logic [1:0] router, input logic [1:0] ttl);
    exp_t e;
    e.is_done = 1'b1;
    e.data    = dfx[DFX-1:AW];
    e.addr    = dfx[AW-1:0];
    e.hdr     = {router, 5'd0, ttl};
    sb.push_back(e);
  endtask

  task automatic send_chunks(input logic [DFX-1:0] dfx, input logic [1:0] router, input logic [1:0] ttl,
                             input int first, input int last, input int gap);
    for (int k = first; k <= last; k++) begin
      send_word(mk_word(dfx, router, k, ttl));
      idle(gap);
    end
  endtask

  task automatic send_frame(input logic [DFX-1:0] dfx, input logic [1:0] router, input logic [1:0] ttl,
                            input int gap);
    send_chunks(dfx, router, ttl, 0, NP-2, gap);
    send_word(mk_word(dfx, router, NP-1, ttl));
    push_done(dfx, router, ttl);
    idle(gap);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_data({tag, "_data"}, data_arbiter_recv, '0);
    check_val({tag, "_addr"}, 64'(router_dst_addr_recv), 64'd0);
    check_val({tag, "_header"}, 64'(header_pkt_recv), 64'd0);
    check_val({tag, "_done"}, 64'(decap_done), 64'd0);
    check_val({tag, "_err"}, 64'(decap_err), 64'd0);
  endtask

  logic [DFX-1:0] fa, fb, fc;

  initial begin
    int waited;
    fa = make_dfx(32'h11111111, 32'h11111111, 10'b0000000001);
    fb = make_dfx(32'hA5A50000, 32'h01020304, 10'h3FF);
    fc = make_dfx(32'hDEADBEEF, 32'h13579BDF, 10'h155);

    rst_n           = 1'b0;
    data_recv       = '0;
    data_recv_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Nominal frame, then identical frame with 3-cycle gaps.
    send_frame(fa, 2'b10, 2'b01, 0);
    idle(3);
    check_val("nominal_header_value", 64'(header_pkt_recv), 64'(9'b10_00000_01));
    send_frame(fa, 2'b10, 2'b01, 3);
    idle(2);

    // Non-zero index while idle.
    send_word(mk_word(fa, 2'b10, 3, 2'b01));
    push_err();
    idle(2);

    // Sequence error: index 5 where 4 expected; outputs hold the last good frame.
    send_chunks(fb, 2'b01, 2'b10, 0, 3, 0);
    send_word(mk_word(fb, 2'b01, 5, 2'b10));
    push_err();
    idle(2);
    check_data("hold_after_err_data", data_arbiter_recv, fa[DFX-1:AW]);
    check_val("hold_after_err_addr", 64'(router_dst_addr_recv), 64'(fa[AW-1:0]));
    send_frame(fb, 2'b01, 2'b10, 0);
    idle(2);

    // Router and TTL mismatches.
    send_chunks(fa, 2'b10, 2'b01, 0, 2, 0);
    send_word(mk_word(fa, 2'b11, 3, 2'b01));
    push_err();
    idle(2);
    send_chunks(fa, 2'b10, 2'b01, 0, 1, 0);
    send_word(mk_word(fa, 2'b10, 2, 2'b00));
    push_err();
    idle(2);

    // Index beyond the frame length.
    send_chunks(fa, 2'b10, 2'b01, 0, 0, 0);
    send_word({2'b10, 5'd20, 2'b01, 55'd0});
    push_err();
    idle(2);

    // Timeout after chunk 7, then a 63-cycle gap that must be tolerated.
    send_chunks(fa, 2'b10, 2'b01, 0, 7, 0);
    push_err();
    idle(64);
    idle(2);
    send_chunks(fc, 2'b11, 2'b00, 0, 5, 0);
    idle(63);
    send_chunks(fc, 2'b11, 2'b00, 6, NP-2, 0);
    send_word(mk_word(fc, 2'b11, NP-1, 2'b00));
    push_done(fc, 2'b11, 2'b00);
    idle(3);

    // Mid-frame restart on index 0.
    send_chunks(fa, 2'b10, 2'b01, 0, 9, 0);
    push_err();
    send_frame(fc, 2'b11, 2'b00, 0);
    idle(3);

    // Back-to-back frames.
    done_cyc.delete();
    send_frame(fa, 2'b10, 2'b01, 0);
    send_frame(fb, 2'b01, 2'b10, 0);
    idle(3);
    check_val("b2b_done_count", 64'(done_cyc.size()), 64'd2);
    if (done_cyc.size() == 2) check_val("b2b_spacing", 64'(done_cyc[1] - done_cyc[0]), 64'd19);

    // Reset in the middle of a frame.
    send_chunks(fc, 2'b11, 2'b00, 0, 10, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(fb, 2'b01, 2'b10, 0);
    idle(3);

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      idle(1);
      waited++;
    end
    check_val("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
